// File: rtl/shift_normalizer.sv
// shift_normalizer: derives the left-shift amount that normalizes a 32-bit
// operand, by leading zeros (mode 00) or by redundant sign bits (mode 01).
// A fixed 5-step binary search (k = 16, 8, 4, 2, 1) runs one step per clock.
// Mode 1x passes the operand straight through. result == value_in << shiftamt
// always holds.
module shift_normalizer #(
  parameter int unsigned ZERO_AMT = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] value_in,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  shiftamt,
  output logic        zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [2:0] LAST_STEP = 3'd4;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  amt_q, amt_d;
  logic        sign_q, sign_d;
  logic [31:0] oper_q, oper_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  shiftamt_q, shiftamt_d;
  logic        zero_q, zero_d;

  logic [4:0]  k;
  logic [31:0] lead_mask;
  logic [31:0] sign_mask;
  logic [31:0] sign_field;
  logic        top_zero;
  logic        top_sign;
  logic        take;
  logic [31:0] step_work;
  logic [4:0]  step_amt;
  logic        op_empty;
  logic        accept;

  // One binary-search step on the working value: test the top k (or k+1) bits.
  always_comb begin
    k          = 5'd16 >> step_q;
    lead_mask  = ~(32'hFFFF_FFFF >> k);
    sign_mask  = ~(32'hFFFF_FFFF >> (6'(k) + 6'd1));
    sign_field = work_q & sign_mask;
    top_zero   = ((work_q & lead_mask) == '0);
    top_sign   = (sign_field == '0) || (sign_field == sign_mask);
    take       = sign_q ? top_sign : top_zero;
    step_work  = take ? (work_q << k) : work_q;
    step_amt   = take ? (amt_q + k) : amt_q;
    // Operand with no normalizing bit is flagged from the latched operand.
    op_empty   = sign_q ? ((oper_q == '0) || (oper_q == '1)) : (oper_q == '0);
  end

  // Next-state, datapath and result-register update.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    work_d     = work_q;
    amt_d      = amt_q;
    sign_d     = sign_q;
    oper_d     = oper_q;
    result_d   = result_q;
    shiftamt_d = shiftamt_q;
    zero_d     = zero_q;
    accept     = start && (state_q != S_SHIFT);

    case (state_q)
      S_SHIFT: begin
        work_d = step_work;
        amt_d  = step_amt;
        step_d = step_q + 3'd1;
        if (step_q == LAST_STEP) begin
          state_d    = S_DONE;
          step_d     = '0;
          result_d   = op_empty ? (oper_q << ZERO_AMT) : step_work;
          shiftamt_d = op_empty ? 5'(ZERO_AMT) : step_amt;
          zero_d     = op_empty;
        end
      end
      S_IDLE, S_DONE: begin
        if (accept) begin
          oper_d = value_in;
          work_d = value_in;
          amt_d  = '0;
          sign_d = mode[0];
          step_d = '0;
          if (mode[1]) begin
            state_d    = S_DONE;
            result_d   = value_in;
            shiftamt_d = '0;
            zero_d     = 1'b0;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; synchronous active-low reset wins over all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      work_q     <= '0;
      amt_q      <= '0;
      sign_q     <= 1'b0;
      oper_q     <= '0;
      result_q   <= '0;
      shiftamt_q <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      work_q     <= work_d;
      amt_q      <= amt_d;
      sign_q     <= sign_d;
      oper_q     <= oper_d;
      result_q   <= result_d;
      shiftamt_q <= shiftamt_d;
      zero_q     <= zero_d;
    end
  end

  assign busy     = (state_q == S_SHIFT);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign shiftamt = shiftamt_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed and random-operand bench for shift_normalizer.
module tb_shift_normalizer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] value_in;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  shiftamt;
  logic        zero;

  int checks = 0;
  int errors = 0;

  shift_normalizer #(.ZERO_AMT(31)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .value_in (value_in),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .shiftamt (shiftamt),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start at the current negedge and wait (bounded) for done.
  // cyc = negedges seen from the accepting edge to the done cycle, inclusive.
  task automatic run_op(input logic [31:0] v, input logic [1:0] m,
                        output logic [31:0] r, output logic [4:0] a,
                        output logic z, output int cyc);
    start = 1'b1; value_in = v; mode = m;
    @(negedge clk);
    start = 1'b0; value_in = 32'hDEAD_BEEF; mode = 2'b00;
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    r = result; a = shiftamt; z = zero;
  endtask

  // Independent reference: linear scan rather than binary search.
  function automatic int unsigned model_amt(input logic [31:0] v, input logic sgn);
    int unsigned n = 0;
    if (sgn) begin
      for (int i = 30; i >= 0; i--) begin
        if (v[i] != v[31]) break;
        n++;
      end
    end else begin
      for (int i = 31; i >= 0; i--) begin
        if (v[i]) break;
        n++;
      end
      if (n > 31) n = 31;
    end
    return n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; value_in = '0; mode = 2'b00;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (shiftamt !== 5'd0) begin errors++; $display("FAIL reset_shiftamt: got %0d expected 0", shiftamt); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", zero); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lead_zero();
    logic [31:0] r; logic [4:0] a; logic z; int cyc;
    run_op(32'h0000_0001, 2'b00, r, a, z, cyc);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL lz1_latency: got %0d expected 6", cyc); end
    checks++; if (a !== 5'd31) begin errors++; $display("FAIL lz1_amt: got %0d expected 31", a); end
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL lz1_result: got %h expected 80000000", r); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL lz1_zero: got %b expected 0", z); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL lz1_done_pulse: got %b expected 0", done); end
    run_op(32'h00F0_0000, 2'b00, r, a, z, cyc);
    checks++; if (a !== 5'd8) begin errors++; $display("FAIL lz2_amt: got %0d expected 8", a); end
    checks++; if (r !== 32'hF000_0000) begin errors++; $display("FAIL lz2_result: got %h expected f0000000", r); end
    @(negedge clk);
  endtask

  task automatic test_lead_sign();
    logic [31:0] r; logic [4:0] a; logic z; int cyc;
    run_op(32'hFFFF_8000, 2'b01, r, a, z, cyc);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL ls1_latency: got %0d expected 6", cyc); end
    checks++; if (a !== 5'd16) begin errors++; $display("FAIL ls1_amt: got %0d expected 16", a); end
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL ls1_result: got %h expected 80000000", r); end
    run_op(32'h0000_0003, 2'b01, r, a, z, cyc);
    checks++; if (a !== 5'd29) begin errors++; $display("FAIL ls2_amt: got %0d expected 29", a); end
    checks++; if (r !== 32'h6000_0000) begin errors++; $display("FAIL ls2_result: got %h expected 60000000", r); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL ls2_zero: got %b expected 0", z); end
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [31:0] r; logic [4:0] a; logic z; int cyc;
    run_op(32'h0000_0000, 2'b00, r, a, z, cyc);
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL z0_zero: got %b expected 1", z); end
    checks++; if (a !== 5'd31) begin errors++; $display("FAIL z0_amt: got %0d expected 31", a); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL z0_result: got %h expected 00000000", r); end
    run_op(32'hFFFF_FFFF, 2'b01, r, a, z, cyc);
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL z1_zero: got %b expected 1", z); end
    checks++; if (a !== 5'd31) begin errors++; $display("FAIL z1_amt: got %0d expected 31", a); end
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL z1_result: got %h expected 80000000", r); end
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    logic [31:0] r; logic [4:0] a; logic z; int cyc;
    run_op(32'hA5A5_0F0F, 2'b10, r, a, z, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL pt_latency: got %0d expected 1", cyc); end
    checks++; if (r !== 32'hA5A5_0F0F) begin errors++; $display("FAIL pt_result: got %h expected a5a50f0f", r); end
    checks++; if (a !== 5'd0) begin errors++; $display("FAIL pt_amt: got %0d expected 0", a); end
    run_op(32'h0000_0000, 2'b11, r, a, z, cyc);
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL pt0_zero: got %b expected 0", z); end
    checks++; if (a !== 5'd0) begin errors++; $display("FAIL pt0_amt: got %0d expected 0", a); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int cyc;
    start = 1'b1; value_in = 32'h00F0_0000; mode = 2'b00;
    @(negedge clk);            // after accepting edge: step 0
    start = 1'b0;
    @(negedge clk);            // step 1
    @(negedge clk);            // step 2
    start = 1'b1; value_in = 32'h1234_5678; mode = 2'b00;
    @(negedge clk);
    start = 1'b0; value_in = '0;
    cyc = 4;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL ign_latency: got %0d expected 6", cyc); end
    checks++; if (shiftamt !== 5'd8) begin errors++; $display("FAIL ign_amt: got %0d expected 8", shiftamt); end
    checks++; if (result !== 32'hF000_0000) begin errors++; $display("FAIL ign_result: got %h expected f0000000", result); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_not_queued: got busy %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start = 1'b1; value_in = 32'h0000_0001; mode = 2'b00;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL b2b_first_result: got %h expected 80000000", result); end
    value_in = 32'h00F0_0000;  // start still high through the done cycle
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b expected 1", busy); end
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL b2b_interval: got %0d expected 6", cyc); end
    checks++; if (result !== 32'hF000_0000) begin errors++; $display("FAIL b2b_second_result: got %h expected f0000000", result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic [4:0] a; logic z; int cyc;
    logic saw_done;
    start = 1'b1; value_in = 32'h0000_0001; mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);            // step 2
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rm_result: got %h expected 00000000", result); end
    checks++; if (shiftamt !== 5'd0) begin errors++; $display("FAIL rm_amt: got %0d expected 0", shiftamt); end
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rm_no_done: got %b expected 0", saw_done); end
    run_op(32'h00F0_0000, 2'b00, r, a, z, cyc);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL rm_after_latency: got %0d expected 6", cyc); end
    checks++; if (a !== 5'd8) begin errors++; $display("FAIL rm_after_amt: got %0d expected 8", a); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] v, r, er; logic [4:0] a; logic z; int cyc;
    logic sgn; int unsigned ea;
    for (int i = 0; i < 12; i++) begin
      sgn = 1'($urandom_range(0, 1));
      v = $urandom;
      if (sgn) v = 32'($signed(v) >>> $urandom_range(0, 31));
      else     v = v >> $urandom_range(0, 31);
      ea = model_amt(v, sgn);
      er = v << ea;
      run_op(v, {1'b0, sgn}, r, a, z, cyc);
      checks++; if (a !== 5'(ea)) begin errors++; $display("FAIL rnd_amt[%0d] v=%h m=%b: got %0d expected %0d", i, v, sgn, a, ea); end
      checks++; if (r !== er) begin errors++; $display("FAIL rnd_result[%0d] v=%h: got %h expected %h", i, v, r, er); end
      checks++; if (r !== (v << a)) begin errors++; $display("FAIL rnd_identity[%0d] v=%h: got %h expected %h", i, v, r, v << a); end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; value_in = '0; mode = 2'b00;
    @(negedge clk);
    test_reset();
    test_lead_zero();
    test_lead_sign();
    test_zero();
    test_passthrough();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_normalizer.md
Name: shift_normalizer

Overview:
- Multi-cycle normalizer: the inverse of the datapath barrel shifter. The barrel shifter applies a given shift amount; this block derives it.
- Given a 32-bit operand, it finds the left-shift amount that normalizes the value, either by leading zeros or by redundant sign bits.
- Returns both the normalized value and the amount. The identity result == value_in << shiftamt always holds.
- Sits beside the shifter in the execute stage. Serves CLZ/CLS-style instructions and any float/fixed-point normalization sequences.
- Uses a start/done handshake with a fixed 5-step binary search.

Parameters:
- ZERO_AMT, 31: shiftamt reported when the operand has no normalizing bit (all-zero, or all-sign in mode 01).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when idle or in the done cycle
- value_in  input  32  operand, sampled with an accepted start
- mode  input  2  00 = leading-zero normalize; 01 = leading-sign normalize; 1x = pass-through
- busy  output  1  high while the search is in progress
- done  output  1  one-cycle pulse; result/shiftamt/zero valid
- result  output  32  normalized value
- shiftamt  output  5  left-shift amount applied
- zero  output  1  operand had no normalizing bit

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; busy, done, zero = 0; result = 0; shiftamt = 0. Reset has priority over every other event.
- States:
  - IDLE
  - SHIFT, with a 3-bit step counter 0..4
  - DONE
- Accept: start high in IDLE or DONE.
  - Latch value_in into the working register; clear the amount accumulator; latch mode.
  - Mode 0x: go to SHIFT with step = 0.
  - Mode 1x: go to DONE with result = value_in, shiftamt = 0, zero = 0.
- start while in SHIFT: ignored, no queuing. The value_in and mode inputs are don't-care outside an accepted start.
- SHIFT step s uses k = 16 >> s (16, 8, 4, 2, 1), one step per clock.
  - Mode 00: if the top k bits of the working value are all 0, shift it left by k and add k to the amount.
  - Mode 01: if the top k+1 bits are all equal to bit 31, shift left by k and add k.
  - Otherwise leave the working value and amount unchanged.
  - After step 4, go to DONE.
- DONE (one cycle):
  - done = 1; result = working value; shiftamt = amount.
  - zero = 1 iff (mode 00 and the operand was 0) or (mode 01 and the operand was 0x00000000 or 0xFFFFFFFF).
  - When zero = 1, shiftamt = ZERO_AMT and result = operand << ZERO_AMT.
  - Next state: SHIFT/DONE if start is accepted this cycle, else IDLE.
- busy = 1 exactly in SHIFT.
- done is deasserted in every state except DONE.
- result, shiftamt and zero hold their values after DONE until the next DONE or reset.
- Latency: a start accepted at edge 0 produces done high during the cycle following edge 5 (mode 0x). Pass-through produces done during the cycle following edge 0.
- Throughput: back-to-back starts in the DONE cycle give one result per 6 cycles (mode 0x).
- Arithmetic:
  - The amount accumulator is 5 bits and cannot exceed 31, so there is no overflow.
  - Shifts are logical left and zero-fill. Mode 01 is guaranteed to keep bit 31 unchanged.
- Reset mid-SHIFT: abort; no done pulse; outputs return to reset values.

Test Plan:
- Reset with rst_n low for 2 cycles -> busy = 0, done = 0, result = 0, shiftamt = 0, zero = 0.
- Mode 00, value_in = 0x00000001 -> done exactly 5 cycles after start, shiftamt = 31, result = 0x80000000, zero = 0. Mode 00, value_in = 0x00F00000 -> shiftamt = 8, result = 0xF0000000.
- Mode 01, value_in = 0xFFFF8000 -> shiftamt = 16, result = 0x80000000. Mode 01, value_in = 0x00000003 -> shiftamt = 29, result = 0x60000000.
- Mode 00, value_in = 0x00000000 -> zero = 1, shiftamt = 31, result = 0. Mode 01, value_in = 0xFFFFFFFF -> zero = 1, shiftamt = 31, result = 0x80000000.
- Handshake checks:
  - start pulsed at cycle 2 of SHIFT with value_in = 0x12345678 -> ignored; the first result completes unchanged.
  - start held high through DONE -> second operation accepted; next done 6 cycles later.
  - Mode 10 -> done the next cycle, result = value_in, shiftamt = 0.
- Reset asserted at SHIFT step 2 -> no done pulse; IDLE next cycle. A start one cycle after reset releases completes normally. For random operands in mode 0x, check result == value_in << shiftamt.
